// File: rtl/load_store_unit.sv
// Load/store unit for a word-wide data memory: one RV32I load or store in flight at a time.
// Define LSU_MISALIGN_SPLIT_EN to execute misaligned accesses (splitting word-crossing ones) instead of trapping them.
module load_store_unit #(
  parameter int MEM_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misalign,
  output logic        rsp_fault,
  output logic        mem_we,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  localparam logic [29:0] WORDS = 30'(MEM_WORDS);

  state_t      state;
  logic        lat_store;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;

  logic [29:0] req_word;
  logic [1:0]  req_off;
  logic [3:0]  size_mask;
  logic        funct3_ok;
  logic        req_fault;
  logic        req_misalign;
  logic [3:0]  acc0_be;
  logic [31:0] acc0_wdata;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [7:0]  be_wide;
  logic [63:0] data_wide;
  logic        req_cross;
  logic        lat_cross;
  logic [3:0]  hi_be;
  logic [31:0] hi_wdata;
  logic [31:0] lo_word;
  logic [31:0] split_aligned;
`endif

  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'b000:  extend_load = {{24{d[7]}}, d[7:0]};
      3'b001:  extend_load = {{16{d[15]}}, d[15:0]};
      3'b100:  extend_load = {24'h0, d[7:0]};
      3'b101:  extend_load = {16'h0, d[15:0]};
      default: extend_load = d;
    endcase
  endfunction

  // Request decode: lane strobes, shifted store data and error classification
  always_comb begin
    req_word = req_addr[31:2];
    req_off  = req_addr[1:0];
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok = 1'b1;
      default:                                funct3_ok = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    // Upper halves of the widened strobes/data belong to the following word
    be_wide      = {4'b0000, size_mask} << req_off;
    data_wide    = {32'h0, req_wdata} << {req_off, 3'b000};
    acc0_be      = be_wide[3:0];
    acc0_wdata   = data_wide[31:0];
    req_cross    = |be_wide[7:4];
    req_fault    = !funct3_ok || (req_word >= WORDS) ||
                   (req_cross && ((req_word + 30'd1) >= WORDS));
    req_misalign = 1'b0;
`else
    acc0_be      = size_mask << req_off;
    acc0_wdata   = req_wdata << {req_off, 3'b000};
    req_fault    = !funct3_ok || (req_word >= WORDS);
    req_misalign = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
`endif
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  always_comb begin
    split_aligned = 32'({mem_rdata, lo_word} >> {lat_off, 3'b000});
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_misalign <= 1'b0;
      rsp_fault    <= 1'b0;
      mem_we       <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_be       <= 4'h0;
      lat_store    <= 1'b0;
      lat_funct3   <= 3'b000;
      lat_off      <= 2'b00;
`ifdef LSU_MISALIGN_SPLIT_EN
      lat_cross    <= 1'b0;
      hi_be        <= 4'h0;
      hi_wdata     <= 32'h0;
      lo_word      <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            lat_store  <= req_store;
            lat_funct3 <= req_funct3;
            lat_off    <= req_off;
            rsp_rdata  <= 32'h0;
            if (req_fault || req_misalign) begin
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_fault    <= req_fault;
              rsp_misalign <= !req_fault && req_misalign;
            end else begin
              state     <= ACC0;
              mem_we    <= req_store;
              mem_rd    <= !req_store;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_be    <= acc0_be;
              mem_wdata <= acc0_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
              lat_cross <= req_cross;
              hi_be     <= be_wide[7:4];
              hi_wdata  <= data_wide[63:32];
`endif
            end
          end
        end
        ACC0: begin
          mem_we <= 1'b0;
          mem_rd <= 1'b0;
          mem_be <= 4'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (lat_cross) begin
            state     <= ACC1;
            mem_we    <= lat_store;
            mem_rd    <= !lat_store;
            mem_addr  <= mem_addr + 32'd4;
            mem_be    <= hi_be;
            mem_wdata <= hi_wdata;
            lo_word   <= mem_rdata;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= lat_store ? 32'h0 :
                         extend_load(mem_rdata >> {lat_off, 3'b000}, lat_funct3);
          end
`else
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= lat_store ? 32'h0 :
                       extend_load(mem_rdata >> {lat_off, 3'b000}, lat_funct3);
`endif
        end
        ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          // Both halves are merged before sign/zero extension
          mem_we    <= 1'b0;
          mem_rd    <= 1'b0;
          mem_be    <= 4'h0;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= lat_store ? 32'h0 : extend_load(split_aligned, lat_funct3);
`else
          state <= IDLE;
`endif
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_fault    <= 1'b0;
            rsp_misalign <= 1'b0;
            req_ready    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-level reference memory model plus randomized traffic.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int MEM_WORDS = 8;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } access_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic        rsp_fault;
  logic        mem_we;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_misalign(rsp_misalign), .rsp_fault(rsp_fault),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory attached to the DUT, plus a log of every access cycle
  logic [31:0] mem [MEM_WORDS];
  logic        init_we = 1'b0;
  logic [2:0]  init_idx = 3'd0;
  logic [31:0] init_data = 32'h0;
  logic [31:0] new_word;
  access_t     acc_q [$];

  assign mem_rdata = (mem_addr[31:2] < 30'(MEM_WORDS)) ? mem[mem_addr[4:2]] : 32'hDEAD0000;

  always @(posedge clk) begin
    if (init_we) begin
      mem[init_idx] <= init_data;
    end else if (mem_we && (mem_addr[31:2] < 30'(MEM_WORDS))) begin
      new_word = mem[mem_addr[4:2]];
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) new_word[8*i +: 8] = mem_wdata[8*i +: 8];
      mem[mem_addr[4:2]] <= new_word;
    end
    if (mem_we || mem_rd) acc_q.push_back({mem_we, mem_addr, mem_be, mem_wdata});
  end

  // Reference model state: byte-addressed memory and expectations of the current request
  logic [7:0]  ref_mem [MEM_WORDS*4];
  logic        exp_fault;
  logic        exp_mis;
  logic [31:0] exp_rdata;
  int          exp_lat;
  int          exp_nacc;
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_be [2];
  logic [31:0] exp_wd [2];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    int     size;
    int     w;
    int     lane;
    longint first;
    longint last;
    longint b;
    logic   legal;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    first = longint'(a) / 4;
    last  = (longint'(a) + size - 1) / 4;
    exp_fault = !legal || (first >= MEM_WORDS) || (SPLIT && (last >= MEM_WORDS));
    exp_mis   = !exp_fault && !SPLIT && ((longint'(a) % size) != 0);
    exp_rdata = 32'h0;
    exp_nacc  = 0;
    exp_lat   = 1;
    for (int k = 0; k < 2; k++) begin
      exp_be[k]   = 4'h0;
      exp_wd[k]   = 32'h0;
      exp_addr[k] = 32'((first + k) * 4);
    end
    if (exp_fault || exp_mis) return;
    exp_lat  = (last != first) ? 3 : 2;
    exp_nacc = int'(last - first) + 1;
    for (int k = 0; k < size; k++) begin
      b    = longint'(a) + k;
      w    = int'(b / 4 - first);
      lane = int'(b % 4);
      exp_be[w][lane] = 1'b1;
      if (st) begin
        exp_wd[w][8*lane +: 8] = wd[8*k +: 8];
        ref_mem[b] = wd[8*k +: 8];
      end else begin
        exp_rdata[8*k +: 8] = ref_mem[b];
      end
    end
    if (!st && (size < 4) && !f3[2] && exp_rdata[8*size-1])
      exp_rdata = exp_rdata | (32'hFFFFFFFF << (8*size));
  endtask

  // One complete request/response transaction, checked against the reference model
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int hold, output logic [31:0] got);
    int          base;
    int          lat;
    logic [31:0] held;
    logic [31:0] lmask;
    access_t     acc;
    ref_model(st, f3, a, wd);
    base = acc_q.size();
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
    checkOutput("rsp_misalign", 32'(rsp_misalign), 32'(exp_mis));
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
    got  = rsp_rdata;
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rdata", rsp_rdata, held);
      checkOutput("hold_mem_idle", {30'h0, mem_we, mem_rd}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_done", 32'(rsp_valid), 32'd0);
    checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    checkOutput("acc_count", 32'(acc_q.size() - base), 32'(exp_nacc));
    for (int k = 0; k < exp_nacc; k++) begin
      if (base + k < acc_q.size()) begin
        acc   = acc_q[base + k];
        lmask = {{8{acc.be[3]}}, {8{acc.be[2]}}, {8{acc.be[1]}}, {8{acc.be[0]}}};
        checkOutput("acc_we", 32'(acc.we), 32'(st));
        checkOutput("acc_addr", acc.addr, exp_addr[k]);
        checkOutput("acc_be", 32'(acc.be), 32'(exp_be[k]));
        if (st) checkOutput("acc_wdata", acc.wd & lmask, exp_wd[k]);
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] d;
    logic        st;
    logic [2:0]  f3;
    logic [2:0]  st_f3 [5];
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

    // Preload both memories identically while reset is held
    for (int w = 0; w < MEM_WORDS; w++) begin
      d = $urandom;
      init_idx  = 3'(w);
      init_data = d;
      init_we   = 1'b1;
      for (int i = 0; i < 4; i++) ref_mem[4*w + i] = d[8*i +: 8];
      @(posedge clk); #1;
    end
    init_we = 1'b0;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", {30'h0, rsp_fault, rsp_misalign}, 32'd0);
    checkOutput("rst_mem_ctl", {28'h0, mem_be}, 32'd0);
    checkOutput("rst_mem_rdwe", {30'h0, mem_we, mem_rd}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 0, got);
    checkOutput("sw_be", 32'(acc_q[$].be), 32'hF);
    applyStimulus(1'b0, 3'b010, 32'h08, 32'h0, 0, got);
    checkOutput("lw_value", got, 32'hDEADBEEF);
    applyStimulus(1'b1, 3'b000, 32'h05, 32'h000000A5, 0, got);
    checkOutput("sb_be", 32'(acc_q[$].be), 32'h2);
    checkOutput("sb_wdata", acc_q[$].wd, 32'h0000A500);
    applyStimulus(1'b0, 3'b000, 32'h05, 32'h0, 1, got);
    checkOutput("lb_value", got, 32'hFFFFFFA5);
    applyStimulus(1'b0, 3'b100, 32'h05, 32'h0, 0, got);
    checkOutput("lbu_value", got, 32'h000000A5);
    applyStimulus(1'b1, 3'b001, 32'h0E, 32'h00008001, 0, got);
    checkOutput("sh_be", 32'(acc_q[$].be), 32'hC);
    applyStimulus(1'b0, 3'b001, 32'h0E, 32'h0, 0, got);
    checkOutput("lh_value", got, 32'hFFFF8001);
    applyStimulus(1'b0, 3'b101, 32'h0E, 32'h0, 0, got);
    checkOutput("lhu_value", got, 32'h00008001);
    applyStimulus(1'b1, 3'b010, 32'h00, 32'h11223344, 0, got);
    applyStimulus(1'b1, 3'b010, 32'h04, 32'h55667788, 0, got);
    applyStimulus(1'b0, 3'b010, 32'h02, 32'h0, 0, got);
`ifdef LSU_MISALIGN_SPLIT_EN
    checkOutput("split_lw_value", got, 32'h77881122);
`else
    checkOutput("lw_misaligned_value", got, 32'h0);
`endif
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 0, got);
    applyStimulus(1'b0, 3'b011, 32'h04, 32'h0, 0, got);
    applyStimulus(1'b0, 3'b010, 32'h1C, 32'h0, 5, got);

    // Reset asserted in the middle of a store access cycle
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0C;
    req_wdata  = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("acc0_mem_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("async_rst_mem_be", 32'(mem_be), 32'd0);
    checkOutput("async_rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h0C, 32'h0, 0, got);

    for (int n = 0; n < 150; n++) begin
      st = 1'($urandom_range(0, 1));
      if (st) f3 = st_f3[$urandom_range(0, 4)];
      else    f3 = 3'($urandom_range(0, 7));
      applyStimulus(st, f3, 32'($urandom_range(0, MEM_WORDS*4 + 3)), $urandom,
                    $urandom_range(0, 2), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts one load/store request at a time from the execute stage.
- Generates the word-aligned address, the 4-bit byte-write strobes and the lane-shifted store data.
- Captures and aligns load data, then zero- or sign-extends it.
- Returns a registered response to the core with valid/ready handshake plus misalign/access-fault error flags.

Parameters:
- MEM_WORDS, 8, number of 32-bit words in the attached data memory; word index >= MEM_WORDS is an access fault.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_misalign  out  1  misaligned-access error.
- rsp_fault  out  1  access fault (out-of-range address or illegal funct3).
- mem_we  out  1  memory write enable.
- mem_rd  out  1  memory read enable.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-shifted store data.
- mem_be  out  4  byte-write strobes, bit i = byte lane i.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_misalign=0; rsp_fault=0; mem_we=0; mem_rd=0; mem_addr=0; mem_wdata=0; mem_be=0.
- FSM states: IDLE, ACC0, ACC1, RESP. ACC1 is reachable only with the optional feature.
- IDLE, on req_valid & req_ready:
  - Latch the request.
  - Illegal funct3 or out-of-range word -> RESP with rsp_fault=1; no memory access.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) and the feature is off -> RESP with rsp_misalign=1; no memory access.
  - Otherwise -> ACC0.
- ACC0: mem_rd=!store, mem_we=store, mem signals driven from registers.
  - Store strobes: B = 0001<<off; H = 0011<<off; W = 1111.
  - Store data: wdata << (8*off).
  - The memory writes on the clock edge that ends ACC0.
  - Loads capture mem_rdata >> (8*off) on that same edge.
  - Next state RESP (or ACC1 when split).
- RESP: rsp_valid=1; outputs held stable until rsp_ready; on rsp_valid & rsp_ready -> IDLE, rsp_valid=0 next cycle.
  - Load extension: B/H sign-extend from bit 7/15; BU/HU zero-extend.
- mem_we, mem_rd and mem_be are 0 in every state except ACC0/ACC1.
- Latency, accept to rsp_valid: 2 cycles for a legal access; 1 cycle for an error; 3 cycles for a split access.
- Back-to-back requests: req_ready returns high the cycle after the response handshake; at most one request is outstanding.
- Error precedence: fault over misalign.
- Reset mid-operation: FSM returns to IDLE immediately and mem_we drops asynchronously. A partly completed split store may leave its first word written; this is accepted.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned accesses inside one word (H at offset 1, B anywhere) complete in ACC0, e.g. H at offset 1 uses be=0110.
  - Accesses crossing a word boundary (H at offset 3; W at offsets 1-3) split in two. ACC0 covers the low word with the upper lanes; ACC1 covers word+1 with the remaining lanes, e.g. W at offset 2 uses be=1100 then be=0011.
  - Load halves are merged before extension.
  - If word+1 is out of range -> fault with no access at all.
  - rsp_misalign is never set.
- Undefined: any misalignment yields an rsp_misalign error response with no memory access.

Test Plan:
- SW addr 0x08, wdata 0xDEADBEEF -> ACC0 with mem_we=1, be=1111, mem_addr=0x08; then LW 0x08 -> rsp_rdata=0xDEADBEEF, 2-cycle latency.
- SB addr 0x05, wdata 0x000000A5 -> be=0010, mem_wdata=0x0000A500; LB 0x05 -> 0xFFFFFFA5; LBU 0x05 -> 0x000000A5.
- SH addr 0x0E, wdata 0x8001 -> be=1100; LH 0x0E -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr 0x02 with the feature off -> rsp_misalign=1, mem_rd never asserted, 1-cycle latency. With LSU_MISALIGN_SPLIT_EN, over words 0x11223344 @0x00 and 0x55667788 @0x04 -> rsp_rdata=0x77881122.
- LW addr 0x20 (word 8, MEM_WORDS=8) -> rsp_fault=1, no memory access. funct3=011 -> rsp_fault=1.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0. Assert rst_n low during ACC0 -> mem_we=0 asynchronously, FSM back in IDLE.
